// File: rtl/reg_writeback_unit.sv
// Write-side master for the register file: merges ALU results with in-order
// load responses, tracks outstanding load destinations and enforces WAW order.
module reg_writeback_unit #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int LDQ_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   ld_issue,
  input  logic [ADDR_W-1:0]      ld_addr,
  output logic                   ld_ready,
  input  logic                   ld_resp_valid,
  input  logic [DATA_W-1:0]      ld_resp_data,
  output logic                   writeEn,
  output logic [ADDR_W-1:0]      writeAddr,
  output logic [DATA_W-1:0]      writeData,
  output logic [(2**ADDR_W)-1:0] pending,
  output logic                   resp_err
);

  localparam int NREG  = 2**ADDR_W;
  localparam int PTR_W = $clog2(LDQ_DEPTH);
  localparam int CNT_W = $clog2(LDQ_DEPTH + 1);

  logic [ADDR_W-1:0] r_q [LDQ_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_alu_acc;
  logic [NREG-1:0]   w_pending;
  logic [PTR_W-1:0]  w_idx;

  assign w_full  = (r_count == CNT_W'(LDQ_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = ld_issue && !w_full;
  assign w_pop   = ld_resp_valid && !w_empty;

  // Walk the live ring entries starting at the head; the head still counts
  // during its pop cycle, so the bit clears one cycle after the response.
  always_comb begin
    w_pending = '0;
    w_idx     = '0;
    for (int unsigned i = 0; i < LDQ_DEPTH; i++) begin
      w_idx = r_rptr + PTR_W'(i);
      if (i < 32'(r_count))
        w_pending = w_pending | (NREG'(1) << r_q[w_idx]);
    end
  end

  assign w_alu_acc = alu_valid && !w_pop && !w_pending[alu_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_q[r_wptr] <= ld_addr;
        r_wptr      <= r_wptr + PTR_W'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CNT_W'(1);

      r_we <= w_pop || w_alu_acc;
      if (w_pop) begin
        r_waddr <= r_q[r_rptr];
        r_wdata <= ld_resp_data;
      end else if (w_alu_acc) begin
        r_waddr <= alu_addr;
        r_wdata <= alu_data;
      end

      if (ld_resp_valid && w_empty)
        r_err <= 1'b1;
    end
  end

  assign alu_ready = w_alu_acc;
  assign ld_ready  = !w_full;
  assign pending   = w_pending;
  assign writeEn   = r_we;
  assign writeAddr = r_waddr;
  assign writeData = r_wdata;
  assign resp_err  = r_err;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Bench for reg_writeback_unit: directed scenarios followed by random traffic,
// all checked against a queue-based reference of the writeback rules.
module tb_reg_writeback_unit;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          ld_issue;
  logic [AW-1:0] ld_addr;
  logic          ld_ready;
  logic          ld_resp_valid;
  logic [DW-1:0] ld_resp_data;
  logic          writeEn;
  logic [AW-1:0] writeAddr;
  logic [DW-1:0] writeData;
  logic [7:0]    pending;
  logic          resp_err;

  reg_writeback_unit #(.DATA_W(DW), .ADDR_W(AW), .LDQ_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_addr(ld_addr), .ld_ready(ld_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
    .pending(pending), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: outstanding load destinations in issue order.
  logic [AW-1:0] mq[$];
  logic          m_we  = 1'b0;
  logic [AW-1:0] m_wa  = '0;
  logic [DW-1:0] m_wd  = '0;
  logic          m_err = 1'b0;
  logic [DW-1:0] mrf [8];
  logic [DW-1:0] dut_rf [8];
  logic [7:0]    last_pending;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, then check the
  // registered outputs 1ns after the rising edge.
  task automatic cyc(input logic rst, input logic av, input logic [AW-1:0] aa,
                     input logic [DW-1:0] ad, input logic li, input logic [AW-1:0] la,
                     input logic lrv, input logic [DW-1:0] ldat);
    logic [7:0] ep;
    logic       pop, acc, push;
    @(negedge clk);
    reset = rst; alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_issue = li; ld_addr = la; ld_resp_valid = lrv; ld_resp_data = ldat;
    #1;
    ep = '0;
    foreach (mq[k]) ep[mq[k]] = 1'b1;
    pop  = lrv && (mq.size() != 0);
    acc  = av && !pop && !ep[aa];
    push = li && (mq.size() != DEPTH);
    last_pending = pending;
    chk("pending", 32'(pending), 32'(ep));
    chk("ld_ready", 32'(ld_ready), 32'(mq.size() != DEPTH));
    if (!rst) chk("alu_ready", 32'(alu_ready), 32'(acc));
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_we = 1'b0; m_wa = '0; m_wd = '0; m_err = 1'b0;
    end else begin
      if (lrv && mq.size() == 0) m_err = 1'b1;
      if (pop) begin
        m_we = 1'b1; m_wa = mq[0]; m_wd = ldat;
        void'(mq.pop_front());
      end else if (acc) begin
        m_we = 1'b1; m_wa = aa; m_wd = ad;
      end else begin
        m_we = 1'b0;
      end
      if (push) mq.push_back(la);
      if (m_we) mrf[m_wa] = m_wd;
    end
    #1;
    chk("writeEn", 32'(writeEn), 32'(m_we));
    chk("writeAddr", 32'(writeAddr), 32'(m_wa));
    chk("writeData", 32'(writeData), 32'(m_wd));
    chk("resp_err", 32'(resp_err), 32'(m_err));
    if (writeEn) dut_rf[writeAddr] = writeData;
  endtask

  task automatic idle();
    cyc(0, 0, '0, '0, 0, '0, 0, '0);
  endtask

  initial begin
    reset = 1'b1; alu_valid = 0; alu_addr = '0; alu_data = '0;
    ld_issue = 0; ld_addr = '0; ld_resp_valid = 0; ld_resp_data = '0;
    for (int i = 0; i < 8; i++) begin mrf[i] = '0; dut_rf[i] = '0; end

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_ld_ready", 32'(ld_ready), 32'h1);

    // Simple ALU write
    cyc(0, 1, 3, 16'h1234, 0, 0, 0, 0);
    chk("alu_w_addr", 32'(writeAddr), 32'h3);
    chk("alu_w_data", 32'(writeData), 32'h1234);
    idle();

    // Two loads, two responses
    cyc(0, 0, 0, 0, 1, 5, 0, 0);
    cyc(0, 0, 0, 0, 1, 6, 0, 0);
    chk("ld_pend_60", 32'(pending), 32'h60);
    cyc(0, 0, 0, 0, 0, 0, 1, 16'hAAAA);
    chk("ld_w5", 32'({writeAddr, writeData}), 32'({3'd5, 16'hAAAA}));
    cyc(0, 0, 0, 0, 0, 0, 1, 16'h5555);
    chk("ld_pend_40", 32'(last_pending), 32'h40);
    chk("ld_w6", 32'({writeAddr, writeData}), 32'({3'd6, 16'h5555}));
    idle();
    chk("ld_pend_00", 32'(last_pending), 32'h00);

    // Fill the queue, refused issues at full
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 3'(i), 0, 0);
    chk("full_ld_ready", 32'(ld_ready), 32'h0);
    cyc(0, 0, 0, 0, 1, 7, 0, 0);
    cyc(0, 0, 0, 0, 1, 7, 1, 16'h0101);
    chk("full_pop_ld_ready", 32'(ld_ready), 32'h1);
    cyc(0, 0, 0, 0, 1, 7, 0, 0);
    chk("refill_ld_ready", 32'(ld_ready), 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, 16'(16'h0200 + i));
    idle();

    // WAW: ALU write to a register with an outstanding load
    cyc(0, 0, 0, 0, 1, 2, 0, 0);
    cyc(0, 1, 2, 16'h0F0F, 0, 0, 0, 0);
    cyc(0, 1, 2, 16'h0F0F, 0, 0, 1, 16'h1111);
    cyc(0, 1, 2, 16'h0F0F, 0, 0, 0, 0);
    cyc(0, 1, 2, 16'h0F0F, 0, 0, 0, 0);
    idle();
    chk("waw_reg2", 32'(dut_rf[2]), 32'h0F0F);

    // Load response and ALU in the same cycle
    cyc(0, 0, 0, 0, 1, 4, 0, 0);
    cyc(0, 1, 1, 16'hBEEF, 0, 0, 1, 16'hCAFE);
    chk("prio_w4", 32'({writeAddr, writeData}), 32'({3'd4, 16'hCAFE}));
    cyc(0, 1, 1, 16'hBEEF, 0, 0, 0, 0);
    idle();
    chk("prio_reg1", 32'(dut_rf[1]), 32'hBEEF);

    // Response with empty queue, then reset with loads queued
    cyc(0, 0, 0, 0, 0, 0, 1, 16'hDEAD);
    chk("err_set", 32'(resp_err), 32'h1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 3'(i + 1), 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_pending", 32'(pending), 32'h0);
    chk("rst_mid_ld_ready", 32'(ld_ready), 32'h1);
    chk("rst_mid_err", 32'(resp_err), 32'h0);

    // Random traffic; ALU request held until accepted
    begin
      logic          av = 0;
      logic [AW-1:0] aa = '0;
      logic [DW-1:0] ad = '0;
      logic          ar;
      for (int n = 0; n < 800; n++) begin
        if (!av && $urandom_range(0, 2) == 0) begin
          av = 1; aa = 3'($urandom_range(0, 7)); ad = 16'($urandom);
        end
        ar = av && !($urandom_range(0, 1) == 1 && mq.size() != 0) ? 1'b0 : 1'b0;
        cyc(($urandom_range(0, 99) == 0), av, aa, ad,
            ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0 && (mq.size() != 0 || $urandom_range(0, 30) == 0)),
            16'($urandom));
        ar = alu_ready;
        if (reset || ar) av = ar ? 1'b0 : av;
      end
    end
    idle(); idle();
    for (int i = 0; i < 8; i++) chk("final_rf", 32'(dut_rf[i]), 32'(mrf[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Write-side master for the 8 x 16-bit register file. It drives the register file's writeEn/writeAddr/writeData port.
- It merges two result sources:
  - single-cycle ALU results;
  - in-order memory load responses, whose destination registers are queued at issue time.
- It exports a pending-register bitmap so decode can detect load-use hazards.
- It enforces write-after-write (WAW) ordering between the two sources.

Parameters:
- DATA_W, 16, width of register data
- ADDR_W, 3, register address width (2**ADDR_W registers)
- LDQ_DEPTH, 4, max outstanding loads (power of 2, at least 2)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- alu_valid  input  1  ALU result present this cycle
- alu_addr  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- alu_ready  output  1  ALU result accepted this cycle (combinational)
- ld_issue  input  1  load issued; push ld_addr into load queue
- ld_addr  input  ADDR_W  load destination register
- ld_ready  output  1  load queue can accept ld_issue
- ld_resp_valid  input  1  load data returning (in issue order)
- ld_resp_data  input  DATA_W  load data
- writeEn  output  1  register file write enable (registered)
- writeAddr  output  ADDR_W  register file write address (registered)
- writeData  output  DATA_W  register file write data (registered)
- pending  output  2**ADDR_W  bit r set while any queued load targets register r
- resp_err  output  1  sticky: ld_resp_valid received with empty load queue

Behaviour:

Interface (already decided):
- One clock, clk.
- reset is synchronous and active-high.

Reset:
- writeEn=0, writeAddr=0, writeData=0, resp_err=0.
- Load queue emptied, so pending=0 and ld_ready=1.
- Reset asserted mid-operation discards every queued load and any in-flight write (writeEn=0 on the following edge).

Load queue:
- Circular FIFO of ADDR_W-bit destination addresses, LDQ_DEPTH entries, with read/write pointers and a count.
- ld_ready = (count != LDQ_DEPTH).
- Push on ld_issue && ld_ready. ld_issue while full is ignored; issuing while full is an upstream error.
- Pop on ld_resp_valid && count != 0.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, the push is still refused that cycle.
- Pointers wrap modulo LDQ_DEPTH.

pending:
- Combinational OR, over all valid entries, of one-hot(entry address).
- Includes the entry being popped this cycle (it clears the cycle after the pop).

Write arbitration (decided each cycle, write presented one cycle later):
1. A load response with a non-empty queue has priority. On the next edge: writeEn=1, writeAddr=queue head, writeData=ld_resp_data.
2. Otherwise, if alu_valid && !pending[alu_addr]: alu_ready=1. On the next edge: writeEn=1, writeAddr=alu_addr, writeData=alu_data.
3. Otherwise writeEn=0 on the next edge; writeAddr/writeData hold their previous values.

ALU acceptance:
- alu_ready = alu_valid && !(ld_resp_valid && count!=0) && !pending[alu_addr].
- The ALU source must hold alu_valid/addr/data until it sees alu_ready.
- The pending check prevents an older ALU write being overwritten, or a younger one being clobbered, by an outstanding load to the same register (WAW).

Error handling:
- ld_resp_valid with count==0 sets resp_err; it stays set until reset.
- No write and no pointer change occur for that response.

Other rules:
- Latency: exactly one clock from acceptance to writeEn. There is no internal buffering beyond the load queue.
- A load to register r issued in the same cycle an ALU write to r is requested: pending is evaluated before the push, so the ALU write is accepted. It precedes the load's write, so ordering is preserved.
- All addresses 0..7 are ordinary registers; none is hardwired.

Test Plan:
- Reset, then alu_valid addr=3 data=0x1234 -> alu_ready=1 same cycle; next cycle writeEn=1, writeAddr=3, writeData=0x1234; the cycle after, writeEn=0.
- ld_issue addr=5, then addr=6; two cycles later ld_resp_valid data=0xAAAA, then data=0x5555 -> writes (5,0xAAAA) then (6,0x5555); pending goes 0x20 -> 0x60 -> 0x40 -> 0x00.
- Issue 4 loads with no responses -> ld_ready=0 and a 5th ld_issue is ignored; then one response plus ld_issue in the same cycle -> count stays 3 after push refusal; a further issue is accepted.
- Outstanding load to reg 2; alu_valid addr=2 data=0x0F0F -> alu_ready=0 until the load response is written; the ALU write lands the cycle after, and the final register value is 0x0F0F.
- ld_resp_valid and alu_valid (addr=1, no pending) in the same cycle -> the load is written first, alu_ready=0; next cycle alu_ready=1 and reg 1 is written.
- ld_resp_valid with an empty queue -> resp_err=1, writeEn=0. Assert reset with 3 loads queued -> pending=0, ld_ready=1, resp_err=0 after the edge.
